// File: rtl/rocev2_sq_meta_arbiter.sv
// Round-robin arbiter sharing the RoCEv2 SQ meta stream among NUM_REQ requesters,
// with per-requester outstanding caps. Optional statistics under SQ_ARB_STATS_EN.
module rocev2_sq_meta_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 352,
  parameter int MAX_OUT = 16,
  parameter int ID_W    = 2
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_REQ*DATA_W-1:0] s_axis_req_tdata,
  input  logic [NUM_REQ-1:0]        s_axis_req_tvalid,
  output logic [NUM_REQ-1:0]        s_axis_req_tready,
  output logic [DATA_W-1:0]         m_axis_sq_meta_tdata,
  output logic [ID_W-1:0]           m_axis_sq_meta_tid,
  output logic                      m_axis_sq_meta_tvalid,
  input  logic                      m_axis_sq_meta_tready,
  input  logic                      cpl_valid,
  input  logic [ID_W-1:0]           cpl_id,
  output logic [NUM_REQ-1:0]        outstanding_full,
  output logic                      err_underflow
`ifdef SQ_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     stat_grant_cnt,
  output logic [31:0]               stat_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt      [NUM_REQ];
  logic [CNT_W-1:0] cnt_next [NUM_REQ];
  logic [NUM_REQ-1:0] full_next;
  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic               slot_free;
  logic               err_set;

  assign slot_free = !m_axis_sq_meta_tvalid || m_axis_sq_meta_tready;

  // Eligibility looks only at the registered count, so a same-cycle completion
  // never lets a capped requester in.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = s_axis_req_tvalid[i] && (cnt[i] < MAX_C);
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(last_grant) + k) % NUM_REQ;
      if (!grant_valid && slot_free && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    s_axis_req_tready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      s_axis_req_tready[i] = grant_valid && (grant_id == ID_W'(i));
    end
  end

  // A grant and a completion for the same requester in one cycle cancel out.
  always_comb begin
    err_set   = 1'b0;
    full_next = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      logic inc;
      logic dec;
      inc = s_axis_req_tready[i];
      dec = cpl_valid && (32'(cpl_id) == i);
      cnt_next[i] = cnt[i];
      if (inc && !dec) begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt[i] == '0) begin
          err_set = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] - CNT_W'(1);
        end
      end
      full_next[i] = (cnt_next[i] == MAX_C);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_axis_sq_meta_tvalid <= 1'b0;
      m_axis_sq_meta_tdata  <= '0;
      m_axis_sq_meta_tid    <= '0;
      last_grant            <= ID_W'(NUM_REQ - 1);
      outstanding_full      <= '0;
      err_underflow         <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (grant_valid) begin
        m_axis_sq_meta_tvalid <= 1'b1;
        m_axis_sq_meta_tdata  <= s_axis_req_tdata[32'(grant_id)*DATA_W +: DATA_W];
        m_axis_sq_meta_tid    <= grant_id;
        last_grant            <= grant_id;
      end else if (slot_free) begin
        m_axis_sq_meta_tvalid <= 1'b0;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= cnt_next[i];
      end
      outstanding_full <= full_next;
      if (err_set) begin
        err_underflow <= 1'b1;
      end
    end
  end

`ifdef SQ_ARB_STATS_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_grant_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (s_axis_req_tready[i]) begin
          stat_grant_cnt[i*32 +: 32] <= stat_grant_cnt[i*32 +: 32] + 32'd1;
        end
      end
      if (m_axis_sq_meta_tvalid && !m_axis_sq_meta_tready) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rocev2_sq_meta_arbiter.sv
// Scoreboard bench for rocev2_sq_meta_arbiter: directed phases push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_rocev2_sq_meta_arbiter;
  localparam int NR = 4;
  localparam int DW = 352;
  localparam int IW = 2;

  typedef struct {
    logic [IW-1:0] tid;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NR*DW-1:0]  s_tdata;
  logic [NR-1:0]     s_tvalid;
  logic [NR-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [IW-1:0]     m_tid;
  logic              m_tvalid;
  logic              m_tready;
  logic              cpl_valid;
  logic [IW-1:0]     cpl_id;
  logic [NR-1:0]     full;
  logic              err;

  logic [DW-1:0] req_data [NR];
  int   seq      [NR];
  int   exp_seq  [NR];
  int   hs_cnt   [NR];
  exp_t sb_q[$];
  int   checks;
  int   errors;

  rocev2_sq_meta_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_OUT(16), .ID_W(IW)) dut (
    .ap_clk(clk),
    .ap_rst_n(rst_n),
    .s_axis_req_tdata(s_tdata),
    .s_axis_req_tvalid(s_tvalid),
    .s_axis_req_tready(s_tready),
    .m_axis_sq_meta_tdata(m_tdata),
    .m_axis_sq_meta_tid(m_tid),
    .m_axis_sq_meta_tvalid(m_tvalid),
    .m_axis_sq_meta_tready(m_tready),
    .cpl_valid(cpl_valid),
    .cpl_id(cpl_id),
    .outstanding_full(full),
    .err_underflow(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_tdata = '0;
    for (int i = 0; i < NR; i++) s_tdata[i*DW +: DW] = req_data[i];
  end

  function automatic logic [DW-1:0] mk(int t, int k);
    logic [31:0] w;
    w = {8'(t), 8'hA5, 16'(k)};
    return {11{w}};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(int t, int n);
    for (int j = 0; j < n; j++) begin
      exp_t e;
      e.tid  = IW'(t);
      e.data = mk(t, exp_seq[t]);
      exp_seq[t]++;
      sb_q.push_back(e);
    end
  endtask

  function automatic int tot();
    int s;
    s = 0;
    for (int i = 0; i < NR; i++) s += hs_cnt[i];
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic run_hs(string name, int start, int n, int maxc);
    for (int j = 0; j < maxc; j++) begin
      step();
      if (tot() - start >= n) return;
    end
    chk({name, "_timeout"}, 64'(tot() - start), 64'(n));
  endtask

  task automatic cpl(int id);
    cpl_valid = 1'b1;
    cpl_id    = IW'(id);
    step();
    cpl_valid = 1'b0;
  endtask

  // Input driver: advances a requester's payload after each accepted handshake.
  initial begin
    logic [NR-1:0] hs;
    for (int i = 0; i < NR; i++) begin
      seq[i] = 0;
      hs_cnt[i] = 0;
      req_data[i] = mk(i, 0);
    end
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          seq[i]++;
          hs_cnt[i]++;
          req_data[i] = mk(i, seq[i]);
        end
      end
    end
  end

  // Monitor: every accepted output beat must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_tvalid && m_tready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got tid %0d with no expected beat", m_tid);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (m_tid !== e.tid || m_tdata !== e.data) begin
            errors++;
            $display("FAIL beat: got tid %0d data %h expected tid %0d data %h",
                     m_tid, m_tdata, e.tid, e.data);
          end
        end
      end
    end
  end

  initial begin
    int start;
    checks = 0;
    errors = 0;
    for (int i = 0; i < NR; i++) exp_seq[i] = 0;
    rst_n = 1'b0;
    s_tvalid = '0;
    m_tready = 1'b1;
    cpl_valid = 1'b0;
    cpl_id = '0;

    #3;
    chk("rst_tvalid", 64'(m_tvalid), 0);
    chk("rst_tdata", 64'(|m_tdata), 0);
    chk("rst_tid", 64'(m_tid), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_err", 64'(err), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Round robin from requester 0, one beat per cycle
    push_exp(0, 1); push_exp(1, 1); push_exp(2, 1); push_exp(3, 1);
    push_exp(0, 1); push_exp(1, 1); push_exp(2, 1); push_exp(3, 1);
    start = tot();
    s_tvalid = 4'hF;
    @(negedge clk);
    chk("first_grant", 64'(s_tready), 64'h1);
    @(negedge clk);
    chk("first_out_valid", 64'(m_tvalid), 1);
    chk("first_out_tid", 64'(m_tid), 0);
    run_hs("rr", start, 8, 20);
    s_tvalid = '0;
    idle(3);
    chk("rr_count", 64'(tot() - start), 8);

    // Backpressure hold, then round robin resumes
    push_exp(0, 1); push_exp(1, 1); push_exp(2, 1); push_exp(3, 1);
    start = tot();
    m_tready = 1'b0;
    s_tvalid = 4'hF;
    step();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("hold_sready", 64'(s_tready), 0);
      chk("hold_tvalid", 64'(m_tvalid), 1);
      chk("hold_tid", 64'(m_tid), 0);
      chk("hold_data", 64'(m_tdata != sb_q[0].data), 0);
    end
    step();
    m_tready = 1'b1;
    run_hs("bp", start, 4, 20);
    s_tvalid = '0;
    idle(3);
    chk("bp_count", 64'(tot() - start), 4);

    // Return every requester to zero outstanding
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < 3; j++) cpl(i);
    end
    chk("no_underflow", 64'(err), 0);
    chk("drained_full", 64'(full), 0);

    // Outstanding cap on requester 1
    push_exp(1, 16);
    start = tot();
    s_tvalid = 4'b0010;
    idle(30);
    chk("cap_count", 64'(tot() - start), 16);
    chk("cap_full", 64'(full), 64'b0010);
    @(negedge clk);
    chk("cap_sready", 64'(s_tready), 0);
    step();
    push_exp(1, 1);
    cpl(1);
    idle(5);
    chk("cap_release_count", 64'(tot() - start), 17);
    chk("cap_refull", 64'(full), 64'b0010);
    s_tvalid = '0;
    idle(2);

    // Same-cycle grant and completion on requester 2 at count 5
    push_exp(2, 5);
    start = tot();
    s_tvalid = 4'b0100;
    run_hs("pre5", start, 5, 20);
    s_tvalid = '0;
    idle(3);
    push_exp(2, 12);
    start = tot();
    s_tvalid = 4'b0100;
    cpl_valid = 1'b1;
    cpl_id = 2'd2;
    step();
    cpl_valid = 1'b0;
    idle(20);
    chk("simul_count", 64'(tot() - start), 12);
    chk("simul_full", 64'(full), 64'b0110);
    s_tvalid = '0;
    idle(2);

    // Underflow on requester 3, counter must stay at zero
    chk("pre_underflow", 64'(err), 0);
    cpl(3);
    chk("underflow_set", 64'(err), 1);
    idle(3);
    chk("underflow_sticky", 64'(err), 1);
    push_exp(3, 16);
    start = tot();
    s_tvalid = 4'b1000;
    idle(30);
    chk("underflow_cnt_zero", 64'(tot() - start), 16);
    chk("all_full", 64'(full), 64'b1110);
    s_tvalid = '0;
    idle(2);

    // Asynchronous reset with a beat pending
    push_exp(0, 1);
    start = tot();
    m_tready = 1'b0;
    s_tvalid = 4'b0001;
    step();
    s_tvalid = '0;
    chk("pend_valid", 64'(m_tvalid), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_tvalid", 64'(m_tvalid), 0);
    chk("async_full", 64'(full), 0);
    chk("async_err", 64'(err), 0);
    void'(sb_q.pop_back());
    idle(2);
    rst_n = 1'b1;
    idle(1);
    push_exp(0, 1); push_exp(3, 1); push_exp(0, 1); push_exp(3, 1);
    start = tot();
    m_tready = 1'b1;
    s_tvalid = 4'b1001;
    @(negedge clk);
    chk("post_rst_grant", 64'(s_tready), 64'h1);
    run_hs("post_rst", start, 4, 20);
    s_tvalid = '0;

    for (int j = 0; j < 20 && sb_q.size() != 0; j++) step();
    idle(2);
    chk("sb_empty", 64'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
